// File: rtl/hack_shift_pkg.sv
// Shared types for the hack_cpu shift engine.
//   shift_mode_e : step applied on each enabled cycle of a frame
//   state_e      : frame sequencer states
package hack_shift_pkg;

  typedef enum logic [1:0] {
    SH_LEFT   = 2'd0,
    SH_RIGHT  = 2'd1,
    ROT_LEFT  = 2'd2,
    ROT_RIGHT = 2'd3
  } shift_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Single combinational shift/rotate step.
//   r      : current register value
//   ser_i  : serial bit shifted in (shift modes only)
//   mode   : step kind
//   r_next : register value after the step
//   ser_o  : bit leaving the register for this mode
module shift_step
  import hack_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] r,
  input  logic             ser_i,
  input  shift_mode_e      mode,
  output logic [WIDTH-1:0] r_next,
  output logic             ser_o
);

  always_comb begin
    r_next = r;
    ser_o  = 1'b0;
    case (mode)
      SH_LEFT: begin
        r_next = {r[WIDTH-2:0], ser_i};
        ser_o  = r[WIDTH-1];
      end
      SH_RIGHT: begin
        r_next = {ser_i, r[WIDTH-1:1]};
        ser_o  = r[0];
      end
      ROT_LEFT: begin
        r_next = {r[WIDTH-2:0], r[WIDTH-1]};
        ser_o  = r[WIDTH-1];
      end
      ROT_RIGHT: begin
        r_next = {r[0], r[WIDTH-1:1]};
        ser_o  = r[0];
      end
      default: begin
        r_next = r;
        ser_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_engine.sv
// Parametrised serial/parallel shift engine with start/busy/done handshake.
//   clk, resetb : clock (rising edge), async active-low reset
//   load_i      : parallel load of data_i (IDLE only)
//   data_i      : parallel load value
//   start_i     : begin a frame (IDLE only); latches mode_i and len_i
//   mode_i      : shift_mode_e encoding
//   len_i       : shifts per frame; 0 or > WIDTH means WIDTH
//   en_i        : step enable; low stalls the frame
//   ser_i       : serial input bit
//   ser_o       : outgoing bit of the current register for the active mode
//   par_o       : register contents
//   busy_o      : frame in progress
//   done_o      : one-cycle frame-complete pulse
module shift_engine
  import hack_shift_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [CW-1:0]    len_i,
  input  logic             en_i,
  input  logic             ser_i,
  output logic             ser_o,
  output logic [WIDTH-1:0] par_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;
  logic [CW-1:0]    len_q;
  logic [CW-1:0]    len_norm;
  shift_mode_e      mode_q;
  shift_mode_e      mode_sel;
  logic [WIDTH-1:0] step_r;
  logic             step_bit;

  always_comb begin
    if (len_i == '0 || len_i > CW'(WIDTH)) begin
      len_norm = CW'(WIDTH);
    end else begin
      len_norm = len_i;
    end
  end

  // One step unit serves both the registered shift and ser_o: outside a
  // frame it previews the live mode_i, inside it follows the latched mode.
  assign mode_sel = (state == SHIFT) ? mode_q : shift_mode_e'(mode_i);
  assign cnt_inc  = cnt + CW'(1);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .r      (sreg),
    .ser_i  (ser_i),
    .mode   (mode_sel),
    .r_next (step_r),
    .ser_o  (step_bit)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      len_q  <= '0;
      mode_q <= SH_LEFT;
    end else begin
      case (state)
        IDLE: begin
          if (load_i) begin
            sreg <= data_i;
          end
          if (start_i) begin
            mode_q <= shift_mode_e'(mode_i);
            len_q  <= len_norm;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (en_i) begin
            sreg <= step_r;
            cnt  <= cnt_inc;
            if (cnt_inc == len_q) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ser_o  = step_bit;
  assign par_o  = sreg;
  assign busy_o = (state == SHIFT);
  assign done_o = (state == DONE);

endmodule

// File: tb/tb_shift_engine.sv
// Scoreboard bench for shift_engine: stimulus pushes expected serial bits,
// final register value and busy length; negedge monitors pop and compare.
module tb_shift_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetb;

  // WIDTH=16 instance
  logic        load, start, en, ser;
  logic [15:0] data;
  logic [1:0]  mode;
  logic [4:0]  len;
  logic        ser_o, busy, done;
  logic [15:0] par;

  // WIDTH=8 instance
  logic        load8, start8, en8, ser8;
  logic [7:0]  data8;
  logic [1:0]  mode8;
  logic [3:0]  len8;
  logic        ser_o8, busy8, done8;
  logic [7:0]  par8;

  shift_engine #(.WIDTH(16)) dut16 (
    .clk(clk), .resetb(resetb), .load_i(load), .data_i(data), .start_i(start),
    .mode_i(mode), .len_i(len), .en_i(en), .ser_i(ser), .ser_o(ser_o),
    .par_o(par), .busy_o(busy), .done_o(done)
  );

  shift_engine #(.WIDTH(8)) dut8 (
    .clk(clk), .resetb(resetb), .load_i(load8), .data_i(data8), .start_i(start8),
    .mode_i(mode8), .len_i(len8), .en_i(en8), .ser_i(ser8), .ser_o(ser_o8),
    .par_o(par8), .busy_o(busy8), .done_o(done8)
  );

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  int exp_ser_q[$];
  int exp_par_q[$];
  int exp_busy_q[$];
  int exp8_ser_q[$];
  int exp8_par_q[$];
  int exp8_busy_q[$];
  int plan_en[$];
  int plan_ser[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on integers.
  function automatic int norm_len(int l, int w);
    return (l == 0 || l > w) ? w : l;
  endfunction

  function automatic int model_out(int r, int m, int w);
    return (m == 0 || m == 2) ? ((r >> (w - 1)) & 1) : (r & 1);
  endfunction

  function automatic int model_next(int r, int m, int s, int w);
    int mask;
    mask = (1 << w) - 1;
    case (m)
      0:       return ((r << 1) | s) & mask;
      1:       return (r >> 1) | (s << (w - 1));
      2:       return ((r << 1) | (r >> (w - 1))) & mask;
      default: return (r >> 1) | ((r & 1) << (w - 1));
    endcase
  endfunction

  // Build per-cycle en/ser plan that ends on the enabled step reaching nl.
  task automatic make_plan(input int nl, input bit rnd_en, input int ser_fix,
                           input int stall_after, input int stall_n);
    int steps, stalls, e;
    plan_en.delete();
    plan_ser.delete();
    steps  = 0;
    stalls = 0;
    while (steps < nl) begin
      if (rnd_en) e = ($urandom_range(0, 3) != 0) ? 1 : 0;
      else e = 1;
      if (!rnd_en && steps == stall_after && stalls < stall_n) begin
        e = 0;
        stalls++;
      end
      plan_en.push_back(e);
      plan_ser.push_back(ser_fix < 0 ? int'($urandom_range(0, 1)) : ser_fix);
      if (e != 0) steps++;
    end
  endtask

  task automatic run_frame(input logic [15:0] d, input int m, input int l,
                           input bit noise, input bit start_in_done);
    int r;
    r = int'(d);
    foreach (plan_en[k]) begin
      if (plan_en[k] != 0) begin
        exp_ser_q.push_back(model_out(r, m, 16));
        r = model_next(r, m, plan_ser[k], 16);
      end
    end
    exp_par_q.push_back(r);
    exp_busy_q.push_back(plan_en.size());

    load  = 1'b1;
    data  = d;
    start = 1'b1;
    mode  = 2'(m);
    len   = 5'(l);
    en    = 1'b0;
    @(posedge clk); #1;
    load  = 1'b0;
    start = 1'b0;
    foreach (plan_en[k]) begin
      en  = plan_en[k][0];
      ser = plan_ser[k][0];
      if (noise) begin
        load  = 1'($urandom_range(0, 1));
        data  = 16'hFFFF;
        start = 1'($urandom_range(0, 1));
        mode  = 2'($urandom_range(0, 3));
        len   = 5'($urandom);
      end
      @(posedge clk); #1;
    end
    // now in DONE: load/start here must be ignored
    en    = 1'b0;
    load  = noise;
    data  = 16'hFFFF;
    start = start_in_done;
    @(posedge clk); #1;
    load  = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor for the 16-bit instance.
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (mon_on && resetb) begin
      if (busy) begin
        if (exp_busy_q.size() == 0) check("spurious_busy", 32'd1, 32'd0);
        busy_cnt++;
        if (en) begin
          if (exp_ser_q.size() == 0) check("ser_underflow", 32'd1, 32'd0);
          else check("ser_o", 32'(ser_o), 32'(exp_ser_q.pop_front()));
        end
      end
      if (done) begin
        if (exp_par_q.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          check("par_o", 32'(par), 32'(exp_par_q.pop_front()));
          check("busy_cycles", 32'(busy_cnt), 32'(exp_busy_q.pop_front()));
          check("busy_in_done", 32'(busy), 32'd0);
        end
        busy_cnt = 0;
      end
    end
  end

  // Monitor for the 8-bit instance.
  int busy8_cnt = 0;
  int done8_cnt = 0;
  always @(negedge clk) begin
    if (mon_on && resetb) begin
      if (busy8) begin
        busy8_cnt++;
        if (en8) begin
          if (exp8_ser_q.size() == 0) check("w8_ser_underflow", 32'd1, 32'd0);
          else check("w8_ser_o", 32'(ser_o8), 32'(exp8_ser_q.pop_front()));
        end
      end
      if (done8) begin
        done8_cnt++;
        if (exp8_par_q.size() == 0) begin
          check("w8_spurious_done", 32'd1, 32'd0);
        end else begin
          check("w8_par_o", 32'(par8), 32'(exp8_par_q.pop_front()));
          check("w8_busy_cycles", 32'(busy8_cnt), 32'(exp8_busy_q.pop_front()));
        end
        busy8_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r8;
    resetb = 1'b0;
    {load, start, en, ser, mode, len, data} = '0;
    {load8, start8, en8, ser8, mode8, len8, data8} = '0;
    #12;
    check("rst_par", 32'(par), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ser", 32'(ser_o), 32'd0);
    check("rst_par8", 32'(par8), 32'd0);
    @(posedge clk); #1;
    resetb = 1'b1;
    @(posedge clk); #1;
    mon_on = 1'b1;

    // SH_LEFT, len 4, ser 1: ser 1,0,1,0 and par 5C3F
    make_plan(4, 1'b0, 1, -1, 0);
    run_frame(16'hA5C3, 0, 4, 1'b0, 1'b0);

    // ROT_RIGHT, len 0 -> 16 steps, value returns
    make_plan(16, 1'b0, 0, -1, 0);
    run_frame(16'h1234, 3, 0, 1'b0, 1'b0);

    // SH_RIGHT, len 3, stall 2 cycles after first shift
    make_plan(3, 1'b0, 0, 1, 2);
    run_frame(16'h000B, 1, 3, 1'b0, 1'b0);

    // Ignored load/start/mode during SHIFT, start/load during DONE
    make_plan(8, 1'b0, -1, -1, 0);
    run_frame(16'h3C5A, 2, 8, 1'b1, 1'b1);

    // IDLE: ser_o follows live mode_i
    load = 1'b1;
    data = 16'h0001;
    @(posedge clk); #1;
    load = 1'b0;
    mode = 2'd1;
    #1 check("idle_ser_right", 32'(ser_o), 32'd1);
    mode = 2'd0;
    #1 check("idle_ser_left", 32'(ser_o), 32'd0);
    check("idle_par", 32'(par), 32'h0001);
    @(posedge clk); #1;

    // Randomized frames
    for (int i = 0; i < 20; i++) begin
      int m, l;
      m = int'($urandom_range(0, 3));
      l = int'($urandom_range(0, 31));
      make_plan(norm_len(l, 16), 1'b1, -1, -1, 0);
      run_frame(16'($urandom), m, l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // WIDTH=8, ROT_LEFT, len 9 -> 8 steps, 8'h81 returns
    r8 = 32'h81;
    for (int k = 0; k < 8; k++) begin
      exp8_ser_q.push_back(model_out(r8, 2, 8));
      r8 = model_next(r8, 2, 0, 8);
    end
    exp8_par_q.push_back(r8);
    exp8_busy_q.push_back(8);
    done8_cnt = 0;
    load8 = 1'b1; data8 = 8'h81; start8 = 1'b1; mode8 = 2'd2; len8 = 4'd9; en8 = 1'b1;
    @(posedge clk); #1;
    load8 = 1'b0; start8 = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("w8_done_pulses", 32'(done8_cnt), 32'd1);
    check("w8_idle_busy", 32'(busy8), 32'd0);

    // Mid-frame async reset: len 8, after 3 shifts
    mon_on = 1'b0;
    load = 1'b1; data = 16'hBEEF; start = 1'b1; mode = 2'd0; len = 5'd8; en = 1'b1; ser = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy_before", 32'(busy), 32'd1);
    resetb = 1'b0;
    #1;
    check("mid_rst_par", 32'(par), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_ser", 32'(ser_o), 32'd0);
    @(posedge clk); #1;
    resetb = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_idle_busy", 32'(busy), 32'd0);
    check("mid_rst_idle_done", 32'(done), 32'd0);
    en = 1'b0;
    mon_on = 1'b1;

    // Fresh frame after reset
    make_plan(5, 1'b1, -1, -1, 0);
    run_frame(16'h8001, 0, 5, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drain_par", 32'(exp_par_q.size()), 32'd0);
    check("queue_drain_ser", 32'(exp_ser_q.size()), 32'd0);
    check("queue_drain_w8", 32'(exp8_par_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
